// File: rtl/seq_search_ctrl.sv
// Sequencer for the serial 8-bit pattern detector: loads the pattern, primes, streams bytes MSB-first.
// Optional SEQ_CTRL_TIMEOUT_EN enables the MAX_BITS search limit and the timeout result.
module seq_search_ctrl #(
    parameter int unsigned MAX_BITS = 1024,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DET_LAT  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    input  logic [7:0]       cfg_pattern,
    output logic             cfg_ready,
    input  logic             cmd_start,
    output logic             busy,
    input  logic             data_valid,
    input  logic [7:0]       data_byte,
    output logic             data_ready,
    output logic             det_set,
    output logic [7:0]       det_word,
    output logic             det_start,
    output logic             det_bit,
    input  logic             det_found,
    output logic             done,
    output logic             hit,
    output logic             timeout,
    output logic             underrun,
    output logic [CNT_W-1:0] match_end
);

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_ARM, S_FEED, S_DRAIN} state_e;

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(DET_LAT);
`ifdef SEQ_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BITS);
`endif

    state_e           state_q, state_d;
    logic [7:0]       det_word_q, det_word_d;
    logic             det_set_q, det_set_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0] drain_q, drain_d;
    logic             pend_to_q, pend_to_d;
    logic             pend_ur_q, pend_ur_d;
    logic             done_q, done_d;
    logic             hit_q, hit_d;
    logic             timeout_q, timeout_d;
    logic             underrun_q, underrun_d;
    logic [CNT_W-1:0] match_end_q, match_end_d;

    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] m;

    assign cfg_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign data_ready = !hold_full_q && ((state_q == S_PRIME) || (state_q == S_FEED));
    assign accept     = data_valid && data_ready;
    assign det_start  = (state_q == S_ARM);
    assign det_bit    = (state_q == S_FEED) ? shreg_q[7] : 1'b0;
    assign det_set    = det_set_q;
    assign det_word   = det_word_q;
    assign done       = done_q;
    assign hit        = hit_q;
    assign timeout    = timeout_q;
    assign underrun   = underrun_q;
    assign match_end  = match_end_q;

`ifdef SEQ_CTRL_TIMEOUT_EN
    assign cnt_inc = bit_cnt_q + CNT_W'(1);
`else
    assign cnt_inc = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
`endif

    // det_found reflects the bit issued DET_LAT+1 cycles earlier; m is its 1-based index
    assign m = (bit_cnt_q >= LAT_C) ? bit_cnt_q - LAT_C : '0;

    always_comb begin
        state_d     = state_q;
        det_word_d  = det_word_q;
        det_set_d   = 1'b0;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        limit_d     = limit_q;
        drain_d     = drain_q;
        pend_to_d   = pend_to_q;
        pend_ur_d   = pend_ur_q;
        done_d      = 1'b0;
        hit_d       = hit_q;
        timeout_d   = timeout_q;
        underrun_d  = underrun_q;
        match_end_d = match_end_q;

        if (accept) begin
            hold_d      = data_byte;
            hold_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    det_set_d  = 1'b1;
                    det_word_d = cfg_pattern;
                end
                if (cmd_start) begin
                    hit_d       = 1'b0;
                    timeout_d   = 1'b0;
                    underrun_d  = 1'b0;
                    match_end_d = '0;
                    hold_full_d = 1'b0;
                    pend_to_d   = 1'b0;
                    pend_ur_d   = 1'b0;
                    state_d     = S_PRIME;
                end
            end
            S_PRIME: begin
                if (accept) state_d = S_ARM;
            end
            S_ARM: begin
                shreg_d     = hold_q;
                hold_full_d = 1'b0;
                bit_cnt_d   = '0;
                state_d     = S_FEED;
            end
            S_FEED: begin
                shreg_d   = {shreg_q[6:0], 1'b0};
                bit_cnt_d = cnt_inc;
                if (det_found) begin
                    hit_d       = 1'b1;
                    match_end_d = m;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    // a byte accepted during the LSB cycle is not bypassed into shreg
                    if (bit_cnt_q[2:0] == 3'd7) begin
                        if (hold_full_q) begin
                            shreg_d     = hold_q;
                            hold_full_d = 1'b0;
                        end else begin
                            limit_d   = cnt_inc;
                            pend_ur_d = 1'b1;
                            drain_d   = LAT_C;
                            state_d   = S_DRAIN;
                        end
                    end
`ifdef SEQ_CTRL_TIMEOUT_EN
                    if (cnt_inc == MAX_C) begin
                        limit_d   = MAX_C;
                        pend_to_d = 1'b1;
                        pend_ur_d = 1'b0;
                        drain_d   = LAT_C;
                        state_d   = S_DRAIN;
                    end
`endif
                end
            end
            S_DRAIN: begin
                bit_cnt_d = cnt_inc;
                if (det_found && (m <= limit_q)) begin
                    hit_d       = 1'b1;
                    match_end_d = m;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end else if (drain_q == '0) begin
                    timeout_d  = pend_to_q;
                    underrun_d = pend_ur_q;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    drain_d = drain_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            det_word_q  <= '0;
            det_set_q   <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            limit_q     <= '0;
            drain_q     <= '0;
            pend_to_q   <= 1'b0;
            pend_ur_q   <= 1'b0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            timeout_q   <= 1'b0;
            underrun_q  <= 1'b0;
            match_end_q <= '0;
        end else begin
            state_q     <= state_d;
            det_word_q  <= det_word_d;
            det_set_q   <= det_set_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            limit_q     <= limit_d;
            drain_q     <= drain_d;
            pend_to_q   <= pend_to_d;
            pend_ur_q   <= pend_ur_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
            timeout_q   <= timeout_d;
            underrun_q  <= underrun_d;
            match_end_q <= match_end_d;
        end
    end

endmodule

// File: tb/tb_seq_search_ctrl.sv
// Scoreboard bench for seq_search_ctrl with a one-stage-latency detector model attached.
module tb_seq_search_ctrl;

    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [7:0]    cfg_pattern = '0;
    logic          cfg_ready;
    logic          cmd_start = 1'b0;
    logic          busy;
    logic          data_valid = 1'b0;
    logic [7:0]    data_byte = '0;
    logic          data_ready;
    logic          det_set;
    logic [7:0]    det_word;
    logic          det_start;
    logic          det_bit;
    logic          det_found;
    logic          done;
    logic          hit;
    logic          timeout;
    logic          underrun;
    logic [CW-1:0] match_end;

    always #5 clk = ~clk;

    seq_search_ctrl #(.MAX_BITS(16), .CNT_W(CW), .DET_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_pattern(cfg_pattern), .cfg_ready(cfg_ready),
        .cmd_start(cmd_start), .busy(busy),
        .data_valid(data_valid), .data_byte(data_byte), .data_ready(data_ready),
        .det_set(det_set), .det_word(det_word), .det_start(det_start),
        .det_bit(det_bit), .det_found(det_found),
        .done(done), .hit(hit), .timeout(timeout), .underrun(underrun),
        .match_end(match_end)
    );

    // Detector: shift register cleared on start, match flag registered once more
    logic [7:0] dm_pat, dm_sr;
    logic       dm_pipe;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_pat  <= '0;
            dm_sr   <= '0;
            dm_pipe <= 1'b0;
        end else begin
            if (det_set) dm_pat <= det_word;
            if (det_start) begin
                dm_sr   <= '0;
                dm_pipe <= 1'b0;
            end else begin
                dm_sr   <= {dm_sr[6:0], det_bit};
                dm_pipe <= (dm_sr == dm_pat);
            end
        end
    end
    assign det_found = dm_pipe;

    typedef struct {
        logic          h;
        logic          t;
        logic          u;
        logic [CW-1:0] me;
        int            lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] stream_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int set_cyc = 0;
    int set_cnt = 0;
    int start_cnt = 0;

    // Byte source: offers the head of stream_q, pops it on handshake
    initial begin
        logic take;
        forever begin
            @(negedge clk);
            data_valid = (stream_q.size() > 0);
            data_byte  = (stream_q.size() > 0) ? stream_q[0] : 8'h00;
            take       = data_valid && data_ready;
            @(posedge clk);
            if (take && stream_q.size() > 0) void'(stream_q.pop_front());
        end
    end

    // Monitor: compares every done pulse against the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (det_set) begin
                set_cnt++;
                set_cyc = cyc;
            end
            if (det_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got done=1 hit=%b to=%b ur=%b me=%0d, required no done",
                             hit, timeout, underrun, match_end);
                end else begin
                    e = exp_q.pop_front();
                    if ({hit, timeout, underrun, match_end, busy} !== {e.h, e.t, e.u, e.me, 1'b0}) begin
                        errors++;
                        $display("FAIL result: got hit=%b to=%b ur=%b me=%0d busy=%b, required hit=%b to=%b ur=%b me=%0d busy=0",
                                 hit, timeout, underrun, match_end, busy, e.h, e.t, e.u, e.me);
                    end
                    checks++;
                    if (cyc - start_cyc != e.lat) begin
                        errors++;
                        $display("FAIL done_latency: got %0d, required %0d cycles after det_start",
                                 cyc - start_cyc, e.lat);
                    end
                end
            end
        end
    end

    task automatic expect_res(input logic h, input logic t, input logic u,
                              input logic [CW-1:0] me, input int lat);
        exp_t e;
        e.h = h; e.t = t; e.u = u; e.me = me; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic cfg_only(input logic [7:0] p);
        @(negedge clk);
        cfg_valid   = 1'b1;
        cfg_pattern = p;
        @(negedge clk);
        cfg_valid   = 1'b0;
    endtask

    task automatic start(input logic with_cfg, input logic [7:0] p);
        @(negedge clk);
        cmd_start = 1'b1;
        if (with_cfg) begin
            cfg_valid   = 1'b1;
            cfg_pattern = p;
        end
        @(negedge clk);
        cmd_start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!det_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!det_start) begin
            checks++;
            errors++;
            $display("FAIL %s_no_start: got det_start=0, required pulse within 50 cycles", name);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_no_done: got %0d pending results, required 0 within 300 cycles",
                     name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        stream_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({cfg_ready, busy, data_ready, det_set, det_word, det_start, det_bit,
             done, hit, timeout, underrun, match_end} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0, {CW{1'b0}}}) begin
            errors++;
            $display("FAIL %s: got rdy=%b busy=%b drdy=%b set=%b word=%h st=%b bit=%b done=%b hit=%b to=%b ur=%b me=%0d, required rdy=1 word=00 rest 0",
                     name, cfg_ready, busy, data_ready, det_set, det_word, det_start, det_bit,
                     done, hit, timeout, underrun, match_end);
        end
    endtask

    initial begin
        int s0, t0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A5 in 0x12,0xA5: completing bit 16, found sampled in DRAIN at bit_cnt 17
        s0 = set_cnt; t0 = start_cnt;
        stream_q = '{8'h12, 8'hA5};
        expect_res(1'b1, 1'b0, 1'b0, 16'd16, 19);
        start(1'b1, 8'hA5);
        wait_done("a5");
        checks++;
        if (set_cnt - s0 != 1 || start_cnt - t0 != 1 || set_cyc >= start_cyc) begin
            errors++;
            $display("FAIL strobes: got set=%0d start=%0d set_cyc=%0d start_cyc=%0d, required one each, set first",
                     set_cnt - s0, start_cnt - t0, set_cyc, start_cyc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({hit, match_end, busy} !== {1'b1, 16'd16, 1'b0}) begin
            errors++;
            $display("FAIL held_flags: got hit=%b me=%0d busy=%b, required hit=1 me=16 busy=0",
                     hit, match_end, busy);
        end

        // 0F across byte boundary of 0x30,0xF0; pattern written before start
        cfg_only(8'h0F);
        stream_q = '{8'h30, 8'hF0};
        expect_res(1'b1, 1'b0, 1'b0, 16'd12, 15);
        start(1'b0, 8'h00);
        wait_done("cross");

        // single byte then starvation
        stream_q = '{8'h11};
        expect_res(1'b0, 1'b0, 1'b1, 16'd0, 11);
        start(1'b1, 8'h3C);
        wait_done("underrun");

        // FF over zero bytes: limit of 16 bits, or underrun after 32 bits without the limit
        stream_q = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef SEQ_CTRL_TIMEOUT_EN
        expect_res(1'b0, 1'b1, 1'b0, 16'd0, 19);
`else
        expect_res(1'b0, 1'b0, 1'b1, 16'd0, 35);
`endif
        start(1'b1, 8'hFF);
        wait_start("limit");
        repeat (20) @(negedge clk);
        checks++;
`ifdef SEQ_CTRL_TIMEOUT_EN
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL limit_busy: got busy=%b at 20 cycles, required 0", busy);
        end
`else
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL limit_busy: got busy=%b at 20 cycles, required 1", busy);
        end
`endif
        wait_done("limit");

        // all-zero pattern matches the cleared detector register
        stream_q = '{8'h5A};
        expect_res(1'b1, 1'b0, 1'b0, 16'd0, 3);
        start(1'b1, 8'h00);
        wait_done("zero_pat");

        // reset in the middle of FEED
        stream_q = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
        start(1'b1, 8'h3C);
        wait_start("abort");
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_feed");
        @(negedge clk);
        stream_q.delete();
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // a clean search after the abort
        stream_q = '{8'h12, 8'hA5};
        expect_res(1'b1, 1'b0, 1'b0, 16'd16, 19);
        start(1'b1, 8'hA5);
        wait_done("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_search_ctrl.md
# seq_search_ctrl

Controller that sequences the serial 8-bit pattern detector. It loads the search pattern, primes and starts a search, and serializes an incoming byte stream MSB-first into the detector with no gaps. It observes the detector's found flag and reports hit, timeout or underrun, plus the position of the matching bit. It sits between the host/byte-stream side and the detector instance.

## Interface
- MAX_BITS, 1024: search length limit in stream bits (1..2^CNT_W−4).
- CNT_W, 16: width of bit counter and match_end.
- DET_LAT, 1: detector latency. It is the number of extra bits issued after the completing bit before det_found is visible.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  pattern write request.
- cfg_pattern  in  8  pattern to search.
- cfg_ready  out  1  high only in IDLE.
- cmd_start  in  1  start a search, sampled in IDLE.
- busy  out  1  high in any state except IDLE.
- data_valid  in  1  byte stream valid.
- data_byte  in  8  stream byte, sent MSB first.
- data_ready  out  1  one-byte holding register empty, and state is PRIME or FEED.
- det_set  out  1  one-cycle pattern load strobe to the detector.
- det_word  out  8  pattern to the detector. Holds the last written value.
- det_start  out  1  one-cycle search start strobe.
- det_bit  out  1  serial bit to the detector. 0 outside FEED.
- det_found  in  1  detector match flag.
- done  out  1  one-cycle pulse when a search ends.
- hit, timeout, underrun  out  1 each  result flags. They are valid from done and held until the next accepted cmd_start.
- match_end  out  CNT_W  1-based index of the stream bit that completed the match. It is 0 unless hit is set.

## Operation
- States: IDLE, PRIME, ARM, FEED, DRAIN.
- IDLE:
  - cfg_valid&&cfg_ready → det_set=1 for one cycle next cycle, det_word←cfg_pattern.
  - cmd_start → clear result flags and the holding register, then go to PRIME.
  - If cfg and start occur in the same cycle, both are accepted. det_set is always issued before det_start.
- PRIME: data_ready=1. When a byte is accepted, go to ARM.
- ARM: det_start=1 for one cycle. Load shreg from the holding register (holding register now empty), set bit_cnt=0, then go to FEED.
- FEED:
  - det_bit=shreg[7] every cycle. bit_cnt increments at the end of each FEED cycle.
  - After the LSB cycle, shreg reloads from the holding register. A byte accepted in the same cycle is not bypassed.
  - If the holding register is empty during the LSB cycle, set limit←bit_cnt+1, mark underrun-pending, and go to DRAIN.
  - When bit_cnt+1==MAX_BITS at the end of a cycle, set limit←MAX_BITS, mark timeout-pending, and go to DRAIN.
- DRAIN: lasts DET_LAT+1 cycles, with det_bit=0. bit_cnt keeps counting issued zeros.
- det_found sampled high in FEED or DRAIN:
  - Compute m = (bit_cnt≥DET_LAT) ? bit_cnt−DET_LAT : 0.
  - If in FEED, or m≤limit: hit=1, match_end=m, done, go to IDLE.
  - Otherwise ignore the sample; it is a match caused by padding zeros.
- DRAIN expiry with no valid hit: done, and assert timeout or underrun per the pending flag, then go to IDLE.
- hit has priority over timeout and underrun.
- Leftover stream bytes are not consumed after done. The holding register is discarded.
- A pattern whose leading bits are zero can match the cleared detector register before 8 bits are issued. This is reported as is; m saturates at 0.

## Timing
- Reset: state IDLE, all outputs 0 except cfg_ready=1. det_word=0, flags 0, match_end 0.
- A reset mid-search aborts immediately with no done.
- cmd_start accepted at cycle t: PRIME from t+1. ARM follows one cycle after the byte handshake. The first det_bit is in the cycle after ARM.
- Sustained throughput is 1 bit/clk. The stream must present the next byte within 8 cycles of the previous accept.
- For a bit issued in FEED cycle k, a resulting det_found is sampled when bit_cnt=k+DET_LAT, so match_end=k.
- done is asserted in the cycle after the deciding sample. busy drops in the same cycle.

## Configuration
- SEQ_CTRL_TIMEOUT_EN defined: the MAX_BITS limit and the timeout path are present.
- Not defined:
  - FEED runs until det_found or underrun. bit_cnt saturates at all-ones, and timeout is tied to 0.
  - MAX_BITS is unused.

## Test plan
- Pattern 0xA5, stream 0x12,0xA5 → hit=1, match_end=16, one det_set and one det_start pulse.
- Pattern 0x0F, stream 0x30,0xF0 (cross-byte) → hit=1, match_end=12.
- Pattern 0x3C, single byte 0x11 then data_valid=0 → underrun=1, hit=0, done 8+DET_LAT+1 cycles after the first det_bit.
- MAX_BITS=16, pattern 0xFF, stream of 0x00 bytes → timeout=1, hit=0. Without the macro, the search runs past 16 bits with busy=1.
- Pattern 0x00, any stream → hit=1, match_end=0.
- rst_n low during FEED → outputs return to reset values at once, no done. The next search works normally.
